cdb_broadcaster: RTL and testbench

- Transmit side of the tag-broadcast interface: collects completed results from NUM_FU functional units and drives up to NUM_TAG CDB lanes per cycle.
- Lanes are per-lane enable + tag + value, consumed by the reservation-station/ROB tag-match CAMs.
- One holding slot per FU, round-robin multi-grant arbitration, registered outputs, valid/ready back-pressure to the FUs, squash on mispredict.

---
 rtl/cdb_broadcaster_pkg.sv | 16 +
 rtl/rr_multi_arbiter.sv | 41 ++++
 rtl/cdb_broadcaster.sv | 111 +++++++++++
 tb/tb_cdb_broadcaster.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB definitions: default sizes and the broadcast lane format seen by
// the reservation-station / ROB tag-match logic.
package sys_defs;

  localparam int unsigned NUM_FU   = 4;
  localparam int unsigned NUM_TAG  = 3;
  localparam int unsigned TAG_SIZE = 6;
  localparam int unsigned DATA_W   = 64;

  typedef struct packed {
    logic                en;
    logic [TAG_SIZE-1:0] tag;
    logic [DATA_W-1:0]   data;
  } CDB_LANE;

endpackage

// File: rtl/rr_multi_arbiter.sv
// Combinational round-robin arbiter granting up to G requesters per cycle,
// scanning upward from ptr_i; grant k lands on lane k so lanes stay packed.
module rr_multi_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned G     = 3,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]          req_i,
  input  logic [PTR_W-1:0]      ptr_i,
  output logic [G-1:0][N-1:0]   grant_oh_o,
  output logic [G-1:0]          lane_valid_o,
  output logic [N-1:0]          grant_o,
  output logic [PTR_W-1:0]      next_ptr_o
);

  localparam int unsigned CNT_W = $clog2(G + 1);

  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_oh_o   = '0;
    lane_valid_o = '0;
    grant_o      = '0;
    next_ptr_o   = ptr_i;
    cnt          = '0;
    idx          = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PTR_W'((32'(ptr_i) + off) % N);
      if (req_i[idx] && (cnt < CNT_W'(G))) begin
        grant_oh_o[cnt][idx] = 1'b1;
        lane_valid_o[cnt]    = 1'b1;
        grant_o[idx]         = 1'b1;
        // Pointer follows the last grant so the next scan starts just past it.
        next_ptr_o           = PTR_W'((32'(idx) + 1) % N);
        cnt                  = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: one holding slot per FU, round-robin multi-grant onto
// NUM_TAG registered broadcast lanes, with squash/reset flushing everything.
module cdb_broadcaster #(
  parameter int unsigned NUM_FU   = sys_defs::NUM_FU,
  parameter int unsigned NUM_TAG  = sys_defs::NUM_TAG,
  parameter int unsigned TAG_SIZE = sys_defs::TAG_SIZE,
  parameter int unsigned DATA_W   = sys_defs::DATA_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU-1:0][TAG_SIZE-1:0]  fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]    fu_data,
  output logic [NUM_FU-1:0]                fu_ready,
  output logic [NUM_TAG-1:0]               cdb_en,
  output logic [NUM_TAG-1:0][TAG_SIZE-1:0] cdb_tag,
  output logic [NUM_TAG-1:0][DATA_W-1:0]   cdb_data
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]                slot_valid_q, slot_valid_d;
  logic [NUM_FU-1:0][TAG_SIZE-1:0]  slot_tag_q,   slot_tag_d;
  logic [NUM_FU-1:0][DATA_W-1:0]    slot_data_q,  slot_data_d;
  logic [PTR_W-1:0]                 rr_ptr_q,     rr_ptr_d;
  logic [NUM_TAG-1:0]               cdb_en_q,     cdb_en_d;
  logic [NUM_TAG-1:0][TAG_SIZE-1:0] cdb_tag_q,    cdb_tag_d;
  logic [NUM_TAG-1:0][DATA_W-1:0]   cdb_data_q,   cdb_data_d;

  logic [NUM_TAG-1:0][NUM_FU-1:0]   grant_oh;
  logic [NUM_TAG-1:0]               lane_valid;
  logic [NUM_FU-1:0]                grant;
  logic [PTR_W-1:0]                 next_ptr;
  logic                             flush;

  rr_multi_arbiter #(
    .N     (NUM_FU),
    .G     (NUM_TAG),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i        (slot_valid_q),
    .ptr_i        (rr_ptr_q),
    .grant_oh_o   (grant_oh),
    .lane_valid_o (lane_valid),
    .grant_o      (grant),
    .next_ptr_o   (next_ptr)
  );

  assign flush = reset | squash;

  // A slot being granted this cycle may be refilled at the same edge.
  assign fu_ready = flush ? '0 : (~slot_valid_q | grant);

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_tag_d   = slot_tag_q;
    slot_data_d  = slot_data_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_en_d     = '0;
    cdb_tag_d    = '0;
    cdb_data_d   = '0;
    if (flush) begin
      slot_valid_d = '0;
      rr_ptr_d     = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (grant[i]) slot_valid_d[i] = 1'b0;
        if (fu_valid[i] && fu_ready[i]) begin
          slot_valid_d[i] = 1'b1;
          slot_tag_d[i]   = fu_tag[i];
          slot_data_d[i]  = fu_data[i];
        end
      end
      cdb_en_d = lane_valid;
      for (int unsigned k = 0; k < NUM_TAG; k++) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
          cdb_tag_d[k]  = cdb_tag_d[k]  | ({TAG_SIZE{grant_oh[k][i]}} & slot_tag_q[i]);
          cdb_data_d[k] = cdb_data_d[k] | ({DATA_W{grant_oh[k][i]}}   & slot_data_q[i]);
        end
      end
      rr_ptr_d = next_ptr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_en_q     <= '0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_en_q     <= cdb_en_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
    end
  end

  always_ff @(posedge clock) begin
    slot_tag_q  <= slot_tag_d;
    slot_data_q <= slot_data_d;
  end

  assign cdb_en   = cdb_en_q;
  assign cdb_tag  = cdb_tag_q;
  assign cdb_data = cdb_data_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: directed scenarios queue their expected
// lane sets; a negedge monitor pops one entry per non-idle broadcast cycle.
module tb_cdb_broadcaster;
  import sys_defs::*;

  typedef CDB_LANE [2:0] exp_t;

  logic             clock = 1'b0;
  logic             reset, squash;
  logic [3:0]       fu_valid;
  logic [3:0][5:0]  fu_tag;
  logic [3:0][63:0] fu_data;
  logic [3:0]       fu_ready;
  logic [2:0]       cdb_en;
  logic [2:0][5:0]  cdb_tag;
  logic [2:0][63:0] cdb_data;

  int   checks = 0;
  int   errors = 0;
  logic mon_on = 1'b0;
  exp_t expq [$];

  always #5 clock = ~clock;

  cdb_broadcaster #(
    .NUM_FU   (4),
    .NUM_TAG  (3),
    .TAG_SIZE (6),
    .DATA_W   (64)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .squash   (squash),
    .fu_valid (fu_valid),
    .fu_tag   (fu_tag),
    .fu_data  (fu_data),
    .fu_ready (fu_ready),
    .cdb_en   (cdb_en),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data)
  );

  function automatic logic [63:0] dat(input int t);
    return 64'hC0DE_0000_0000_0000 | 64'(t);
  endfunction

  function automatic exp_t mk(input logic [2:0] en, input int t0, input int t1, input int t2);
    exp_t e;
    int   t [3];
    t[0] = t0; t[1] = t1; t[2] = t2;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      if (en[k]) begin
        e[k].en   = 1'b1;
        e[k].tag  = 6'(t[k]);
        e[k].data = dat(t[k]);
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int i, input int t);
    fu_tag[i]  = 6'(t);
    fu_data[i] = dat(t);
  endtask

  // Monitor: every broadcast must match the oldest queued expectation.
  always @(negedge clock) begin
    if (mon_on) begin
      if (cdb_en != 3'b000) begin
        if (expq.size() == 0) begin
          check("unexpected_broadcast", {cdb_en, cdb_tag}, '0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          for (int k = 0; k < 3; k++) begin
            check($sformatf("lane%0d_en", k),   cdb_en[k],   e[k].en);
            check($sformatf("lane%0d_tag", k),  cdb_tag[k],  e[k].tag);
            check($sformatf("lane%0d_data", k), cdb_data[k], e[k].data);
          end
        end
      end else begin
        check("idle_lanes_zero", {cdb_tag, cdb_data}, '0);
      end
    end
  end

  initial begin
    logic [3:0] fair_rdy [8];
    fair_rdy = '{4'b1111, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111, 4'b1011, 4'b1101};

    reset = 1'b1; squash = 1'b0; fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) drive(i, 60 + i);

    // Reset held two cycles with all FUs presenting.
    for (int c = 0; c < 2; c++) begin
      tick;
      mon_on = 1'b1;
      #2;
      check("reset_ready", fu_ready, 4'b0000);
      check("reset_en",    cdb_en,   3'b000);
      check("reset_tag",   cdb_tag,  '0);
      check("reset_data",  cdb_data, '0);
    end
    reset = 1'b0; fu_valid = 4'b0000;
    #1 check("ready_after_reset", fu_ready, 4'b1111);

    // Single result: FU1 tag 5, data 0xAA.
    begin
      exp_t e;
      e = mk(3'b001, 5, 0, 0);
      e[0].data = 64'hAA;
      expq.push_back(e);
    end
    fu_valid = 4'b0010; fu_tag[1] = 6'd5; fu_data[1] = 64'hAA;
    tick; fu_valid = 4'b0000;
    tick;
    tick; check("single_en_cleared", cdb_en, 3'b000);

    // Return rr_ptr to 0 via a one-cycle squash on empty slots.
    squash = 1'b1; tick; squash = 1'b0;

    // Overflow: four results, three lanes.
    expq.push_back(mk(3'b111, 1, 2, 3));
    expq.push_back(mk(3'b001, 4, 0, 0));
    fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) drive(i, i + 1);
    #1 check("ovf_ready_accept", fu_ready, 4'b1111);
    tick; fu_valid = 4'b0000;
    #1 check("ovf_ready_wait", fu_ready, 4'b0111);
    tick;
    #1 check("ovf_ready_back", fu_ready, 4'b1111);
    tick; tick;

    // Fairness: all FUs valid continuously from reset.
    reset = 1'b1; tick; tick; reset = 1'b0;
    fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) drive(i, 16 + i);
    expq.push_back(mk(3'b111, 16, 17, 18));
    expq.push_back(mk(3'b111, 19, 16, 17));
    expq.push_back(mk(3'b111, 18, 19, 16));
    expq.push_back(mk(3'b111, 17, 18, 19));
    expq.push_back(mk(3'b111, 16, 17, 18));
    expq.push_back(mk(3'b111, 19, 16, 17));
    expq.push_back(mk(3'b111, 18, 19, 16));
    expq.push_back(mk(3'b111, 17, 18, 19));
    expq.push_back(mk(3'b001, 16, 0, 0));
    for (int c = 0; c < 8; c++) begin
      #1 check($sformatf("fair_ready_c%0d", c), fu_ready, fair_rdy[c]);
      tick;
    end
    fu_valid = 4'b0000;
    repeat (4) tick;

    // Squash with slots 0 and 2 occupied and FU1 presenting.
    fu_valid = 4'b0101; drive(0, 40); drive(2, 42);
    tick;
    squash = 1'b1; fu_valid = 4'b0010; drive(1, 41);
    #1 check("squash_ready", fu_ready, 4'b0000);
    tick;
    squash = 1'b0; fu_valid = 4'b0000;
    #1 check("squash_en", cdb_en, 3'b000);
    check("squash_ready_after", fu_ready, 4'b1111);

    // rr_ptr back at 0: slot 0 must precede slot 3.
    expq.push_back(mk(3'b011, 50, 53, 0));
    fu_valid = 4'b1001; drive(0, 50); drive(3, 53);
    tick; fu_valid = 4'b0000;
    repeat (3) tick;

    // Back-pressure: FU3 holds tag 9 while its slot waits for a grant.
    expq.push_back(mk(3'b111, 20, 21, 22));
    expq.push_back(mk(3'b001, 23, 0, 0));
    expq.push_back(mk(3'b001, 9, 0, 0));
    fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) drive(i, 20 + i);
    tick;
    fu_valid = 4'b1000; drive(3, 9);
    #1 check("bp_ready_low", fu_ready[3], 1'b0);
    tick;
    #1 check("bp_ready_rise", fu_ready[3], 1'b1);
    tick; fu_valid = 4'b0000;
    repeat (5) tick;

    check("scoreboard_drained", 192'(expq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
